// File: rtl/alu_control_seq_pkg.sv
// Shared definitions for alu_control_seq: funct codes, ALU control codes,
// mult/div sequencer state type and counter load helper.
package alu_ctrl_pkg;

    localparam logic [5:0] FN_AND  = 6'b000100;
    localparam logic [5:0] FN_OR   = 6'b000101;
    localparam logic [5:0] FN_ADD  = 6'b000010;
    localparam logic [5:0] FN_SUB  = 6'b000011;
    localparam logic [5:0] FN_SLT  = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;

    localparam logic [2:0] CTR_AND = 3'd0;
    localparam logic [2:0] CTR_OR  = 3'd1;
    localparam logic [2:0] CTR_SLT = 3'd4;
    localparam logic [2:0] CTR_ADD = 3'd5;
    localparam logic [2:0] CTR_SUB = 3'd6;

    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } md_state_e;

    // RUN lasts LAT cycles, so the down-counter is loaded with LAT-1.
    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/alu_control_seq_if.sv
// EX-stage control bundle between the main control unit (master) and
// alu_control_seq (slave).
interface alu_control_seq_if #(
    parameter int OP_W  = 3,
    parameter int CTR_W = 3
);
    logic             valid;
    logic             flush;
    logic [OP_W-1:0]  ALUop;
    logic [5:0]       function_code;
    logic [CTR_W-1:0] alu_ctr;
    logic             jr;
    logic             illegal;
    logic             stall;
    logic             md_start;
    logic             md_op;
    logic             md_busy;
    logic             hilo_we;

    modport master (
        output valid, flush, ALUop, function_code,
        input  alu_ctr, jr, illegal, stall, md_start, md_op, md_busy, hilo_we
    );

    modport slave (
        input  valid, flush, ALUop, function_code,
        output alu_ctr, jr, illegal, stall, md_start, md_op, md_busy, hilo_we
    );
endinterface

// File: rtl/alu_control_seq_decode.sv
// alu_funct_decode: combinational ALUop/funct -> alu_ctr and instruction class.
// Divide is decoded only when ALU_CTRL_DIV_EN is defined; otherwise it is illegal.
module alu_funct_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W  = 3,
    parameter int CTR_W = 3
)(
    input  logic [OP_W-1:0]  i_aluop,
    input  logic [5:0]       i_funct,
    input  logic             i_valid,
    output logic [CTR_W-1:0] o_alu_ctr,
    output logic             o_jr,
    output logic             o_illegal,
    output logic             o_is_mult,
    output logic             o_is_div,
    output logic             o_is_hilo_rd
);
    logic w_rtype;

    // Funct table lookup; non-R-type ops pass ALUop straight through.
    always_comb begin
        w_rtype      = (i_aluop == {OP_W{1'b1}});
        o_alu_ctr    = '0;
        o_jr         = 1'b0;
        o_illegal    = 1'b0;
        o_is_mult    = 1'b0;
        o_is_div     = 1'b0;
        o_is_hilo_rd = 1'b0;
        if (!w_rtype) begin
            o_alu_ctr = CTR_W'(i_aluop);
        end else begin
            case (i_funct)
                FN_AND:  o_alu_ctr = CTR_W'(CTR_AND);
                FN_OR:   o_alu_ctr = CTR_W'(CTR_OR);
                FN_ADD:  o_alu_ctr = CTR_W'(CTR_ADD);
                FN_SUB:  o_alu_ctr = CTR_W'(CTR_SUB);
                FN_SLT:  o_alu_ctr = CTR_W'(CTR_SLT);
                FN_JR:   o_jr      = 1'b1;
                FN_MULT: o_is_mult = 1'b1;
`ifdef ALU_CTRL_DIV_EN
                FN_DIV:  o_is_div  = 1'b1;
`endif
                FN_MFHI, FN_MFLO: o_is_hilo_rd = 1'b1;
                default: o_illegal = i_valid;
            endcase
        end
    end
endmodule

// File: rtl/alu_control_seq.sv
// alu_control_seq: ALU control decode plus IDLE/RUN/DONE mult/div sequencer.
// Macro ALU_CTRL_DIV_EN enables divide; without it md_op stays 0.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W     = 3,
    parameter int CTR_W    = 3,
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32
)(
    input  logic             clk,
    input  logic             reset,
    alu_control_seq_if.slave bus
);
    localparam logic [CNT_W-1:0] MULT_LOAD = lat_load(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD  = lat_load(DIV_LAT);

    md_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_md_op, w_md_op_nxt;
    logic             r_md_start, r_md_busy, r_hilo_we;
    logic [CTR_W-1:0] w_alu_ctr;
    logic             w_jr, w_illegal, w_is_mult, w_is_div, w_is_hilo_rd;
    logic             w_md_req, w_accept;

    alu_funct_decode #(.OP_W(OP_W), .CTR_W(CTR_W)) u_decode (
        .i_aluop      (bus.ALUop),
        .i_funct      (bus.function_code),
        .i_valid      (bus.valid),
        .o_alu_ctr    (w_alu_ctr),
        .o_jr         (w_jr),
        .o_illegal    (w_illegal),
        .o_is_mult    (w_is_mult),
        .o_is_div     (w_is_div),
        .o_is_hilo_rd (w_is_hilo_rd)
    );

    assign w_md_req = w_is_mult | w_is_div;
    assign w_accept = bus.valid & w_md_req & (r_state == IDLE) & ~bus.flush;

    // Next-state and counter/op update for the mult/div sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_md_op_nxt = r_md_op;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = w_is_div ? DIV_LOAD : MULT_LOAD;
                    w_md_op_nxt = w_is_div;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (bus.flush) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Sequencer state and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_md_op    <= 1'b0;
            r_md_start <= 1'b0;
            r_md_busy  <= 1'b0;
            r_hilo_we  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_md_op    <= w_md_op_nxt;
            r_md_start <= w_accept;
            r_md_busy  <= (w_state_nxt != IDLE);
            r_hilo_we  <= (w_state_nxt == DONE);
        end
    end

    assign bus.alu_ctr  = w_alu_ctr;
    assign bus.jr       = w_jr;
    assign bus.illegal  = w_illegal;
    assign bus.stall    = bus.valid & (w_md_req | w_is_hilo_rd) & (r_state != IDLE);
    assign bus.md_start = r_md_start;
    assign bus.md_op    = r_md_op;
    assign bus.md_busy  = r_md_busy;
    assign bus.hilo_we  = r_hilo_we;
endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: directed steps then random traffic
// against an age-based reference model of the mult/div sequencer.
module tb_alu_control_seq;
    localparam int OP_W     = 3;
    localparam int CTR_W    = 3;
    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 32;
`ifdef ALU_CTRL_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    // Reference model: cycles since accept (0 = idle), latency and op of the job.
    int   m_age = 0;
    int   m_lat = MULT_LAT;
    logic m_op  = 1'b0;

    logic [5:0] picks [0:11] = '{6'd4, 6'd5, 6'd2, 6'd3, 6'd7, 6'd8,
                                 6'd24, 6'd26, 6'd16, 6'd18, 6'd24, 6'd0};

    alu_control_seq_if #(.OP_W(OP_W), .CTR_W(CTR_W)) bus ();

    alu_control_seq #(.OP_W(OP_W), .CTR_W(CTR_W), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic bit is_rtype(input logic [OP_W-1:0] op);
        return op == {OP_W{1'b1}};
    endfunction

    function automatic int ref_ctr(input logic [OP_W-1:0] op, input logic [5:0] f);
        if (!is_rtype(op)) return int'(op) & ((1 << CTR_W) - 1);
        case (f)
            6'd4:    return 0;
            6'd5:    return 1;
            6'd2:    return 5;
            6'd3:    return 6;
            6'd7:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit ref_md(input logic [5:0] f);
        return (f == 6'd24) || (DIV_ON && f == 6'd26);
    endfunction

    function automatic bit ref_hilo(input logic [5:0] f);
        return (f == 6'd16) || (f == 6'd18);
    endfunction

    function automatic bit ref_known(input logic [5:0] f);
        return ref_md(f) || ref_hilo(f) || f == 6'd4 || f == 6'd5 || f == 6'd2 ||
               f == 6'd3 || f == 6'd7 || f == 6'd8;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input bit fl, input logic [OP_W-1:0] op, input logic [5:0] f);
        bus.valid         = v;
        bus.flush         = fl;
        bus.ALUop         = op;
        bus.function_code = f;
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [OP_W-1:0] op = bus.ALUop;
        logic [5:0]      f  = bus.function_code;
        bit              rt = is_rtype(op);
        bit              v  = bus.valid;
        chk({tag, ".ctr"},     32'(bus.alu_ctr),  32'(ref_ctr(op, f)));
        chk({tag, ".jr"},      32'(bus.jr),       32'(rt && f == 6'd8));
        chk({tag, ".illegal"}, 32'(bus.illegal),  32'(rt && v && !ref_known(f)));
        chk({tag, ".stall"},   32'(bus.stall),    32'(v && rt && (ref_md(f) || ref_hilo(f)) && m_age >= 1));
        chk({tag, ".start"},   32'(bus.md_start), 32'(m_age == 1));
        chk({tag, ".busy"},    32'(bus.md_busy),  32'(m_age >= 1));
        chk({tag, ".hilo"},    32'(bus.hilo_we),  32'(m_age >= 1 && m_age == m_lat + 1));
        chk({tag, ".op"},      32'(bus.md_op),    32'(m_op));
    endtask

    // Advance one clock edge; the model consumes the inputs present before the edge.
    task automatic tick();
        bit              rs = reset;
        bit              v  = bus.valid;
        bit              fl = bus.flush;
        logic [OP_W-1:0] op = bus.ALUop;
        logic [5:0]      f  = bus.function_code;
        @(posedge clk);
        if (rs) begin
            m_age = 0;
            m_op  = 1'b0;
        end else if (m_age != 0) begin
            if (m_age == m_lat + 1 || fl) m_age = 0;
            else                          m_age++;
        end else if (v && is_rtype(op) && ref_md(f) && !fl) begin
            m_age = 1;
            m_lat = (f == 6'd26) ? DIV_LAT : MULT_LAT;
            m_op  = (f == 6'd26);
        end
        @(negedge clk);
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        m_age = 0;
        m_op  = 1'b0;
        chk({tag, ".rst_busy"},  32'(bus.md_busy),  32'd0);
        chk({tag, ".rst_start"}, 32'(bus.md_start), 32'd0);
        chk({tag, ".rst_hilo"},  32'(bus.hilo_we),  32'd0);
        chk({tag, ".rst_op"},    32'(bus.md_op),    32'd0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.valid = 1'b0; bus.flush = 1'b0; bus.ALUop = '0; bus.function_code = '0;
        @(negedge clk);
        drive(0, 0, 3'd0, 6'd0);
        check_all("reset");
        tick();
        reset = 1'b0;

        drive(1, 0, 3'b010, 6'd0);
        check_all("op010");
        chk("op010_lit", 32'(bus.alu_ctr), 32'd2);
        chk("op010_stall", 32'(bus.stall), 32'd0);
        tick();
        drive(1, 0, 3'b111, 6'b000011);
        check_all("sub");
        chk("sub_lit", 32'(bus.alu_ctr), 32'd6);
        tick();
        drive(1, 0, 3'b111, 6'b001000);
        check_all("jr");
        chk("jr_lit", 32'(bus.jr), 32'd1);
        tick();
        drive(1, 0, 3'b111, 6'b111111);
        check_all("ill_v1");
        chk("ill_v1_lit", 32'(bus.illegal), 32'd1);
        tick();
        drive(0, 0, 3'b111, 6'b111111);
        check_all("ill_v0");
        chk("ill_v0_lit", 32'(bus.illegal), 32'd0);
        tick();

        drive(1, 0, 3'b111, 6'd24);
        check_all("mult_acc");
        tick();
        for (int c = 1; c <= 6; c++) begin
            drive(1, 0, 3'b111, 6'd2);
            check_all("mult_run");
            chk("mult_start", 32'(bus.md_start), 32'(c == 1));
            chk("mult_busy",  32'(bus.md_busy),  32'(c <= 5));
            chk("mult_hilo",  32'(bus.hilo_we),  32'(c == 5));
            chk("mult_op",    32'(bus.md_op),    32'd0);
            tick();
        end

        drive(1, 0, 3'b111, 6'd26);
        check_all("div_acc");
`ifndef ALU_CTRL_DIV_EN
        chk("nodiv_illegal", 32'(bus.illegal), 32'd1);
`endif
        tick();
        for (int c = 1; c <= DIV_LAT + 2; c++) begin
            if (c == 2) drive(1, 0, 3'b111, 6'd2);
            else        drive(1, 0, 3'b111, 6'd18);
            check_all("div_dep");
`ifdef ALU_CTRL_DIV_EN
            chk("div_stall", 32'(bus.stall), 32'((c <= DIV_LAT + 1) && (c != 2)));
            chk("div_op", 32'(bus.md_op), 32'd1);
`else
            chk("nodiv_start", 32'(bus.md_start), 32'd0);
`endif
            tick();
        end

        drive(1, 0, 3'b111, 6'd24);
        check_all("fl_acc");
        tick();
        for (int c = 1; c <= 7; c++) begin
            drive(c == 3, c == 3, 3'b111, 6'd0);
            check_all("fl_run");
            chk("fl_hilo", 32'(bus.hilo_we), 32'd0);
            if (c >= 4) chk("fl_busy", 32'(bus.md_busy), 32'd0);
            tick();
        end

        drive(1, 1, 3'b111, 6'd24);
        check_all("fl_idle");
        tick();
        drive(0, 0, 3'b111, 6'd0);
        check_all("fl_idle_next");
        chk("fl_idle_start", 32'(bus.md_start), 32'd0);
        tick();

        drive(1, 0, 3'b111, 6'd24);
        check_all("fld_acc");
        tick();
        for (int c = 1; c <= 6; c++) begin
            drive(0, c == 5, 3'b111, 6'd0);
            check_all("fld_run");
            chk("fld_hilo", 32'(bus.hilo_we), 32'(c == 5));
            tick();
        end

        drive(1, 0, 3'b111, 6'd24);
        check_all("ar_acc");
        tick();
        drive(0, 0, 3'b111, 6'd0);
        check_all("ar_run1");
        tick();
        drive(0, 0, 3'b111, 6'd0);
        check_all("ar_run2");
        async_reset("ar");
        drive(0, 0, 3'b111, 6'd0);
        check_all("ar_after");
        tick();

        for (int i = 0; i < 3000; i++) begin
            logic [OP_W-1:0] op;
            logic [5:0]      f;
            op = ($urandom_range(0, 2) == 0) ? OP_W'($urandom) : {OP_W{1'b1}};
            f  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : picks[$urandom_range(0, 11)];
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, op, f);
            check_all("rnd");
            if ($urandom_range(0, 199) == 0) async_reset("rnd");
            else                             tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_control_seq.md
# alu_control_seq

Parametrised successor to the single-cycle ALU control decoder for the MIPS datapath. Decodes `ALUop` and the R-type function field into the ALU control code like its predecessor. It also sequences multi-cycle multiply/divide through a small state machine, with a start pulse, busy/stall handshake, flush and a HI/LO write strobe. It sits between the main control unit and the ALU / mult-div unit in the EX stage.

## Interface
- `OP_W`, 3: width of `ALUop`; all-ones means R-type.
- `CTR_W`, 3: width of `alu_ctr`; must be ≥3.
- `MULT_LAT`, 4: multiply run cycles, ≥1.
- `DIV_LAT`, 32: divide run cycles, ≥1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `valid` in 1: the instruction in EX is real.
- `flush` in 1: synchronous cancel of any running mult/div.
- `ALUop` in OP_W: op class from main control.
- `function_code` in 6: R-type funct field.
- `alu_ctr` out CTR_W: ALU operation code (combinational).
- `jr` out 1: R-type jump-register decoded (combinational).
- `illegal` out 1: R-type with an unsupported funct while `valid` (combinational).
- `stall` out 1: hold the pipeline (combinational).
- `md_start` out 1: one-cycle start pulse to the mult-div unit (registered).
- `md_op` out 1: 0 = mult, 1 = div; latched at accept (registered).
- `md_busy` out 1: a mult/div is in flight (registered).
- `hilo_we` out 1: one-cycle HI/LO write strobe (registered).

## Operation
- Non-R-type (`ALUop` ≠ all-ones): `alu_ctr` = `ALUop` zero-extended or truncated to CTR_W.
- R-type funct → `alu_ctr`:
  - 000100 and → 0
  - 000101 or → 1
  - 000010 add → 5
  - 000011 sub → 6
  - 000111 slt → 4
  - 001000 jr → 0, with `jr`=1
- Mult/div funct codes: 011000 mult, 011010 div, 010000 mfhi, 010010 mflo. All four give `alu_ctr`=0.
- Any other R-type funct → `alu_ctr`=0; `illegal`=1 if `valid`.
- States IDLE, RUN, DONE. A 6-bit down-counter `cnt` covers the max of MULT_LAT and DIV_LAT.
- Accept condition: `valid` & (mult|div) & state=IDLE & !`flush`. On accept:
  - next state → RUN
  - `cnt` ← LAT−1
  - `md_op` latched
  - `md_start`=1 for the next cycle only
- RUN: `cnt` decrements each cycle. At `cnt`=0 the next state is DONE.
- DONE: lasts exactly one cycle with `hilo_we`=1, then → IDLE.
- `md_busy`=1 in RUN and DONE.
- `stall` = `valid` & (mult|div|mfhi|mflo) & state≠IDLE. Other instructions never stall.
- `flush` in RUN → IDLE next cycle; no DONE, no `hilo_we`.
- `flush` in DONE → `hilo_we` still asserted that cycle, since the write is committed.
- `flush` has priority over accept.
- `reset` mid-run → IDLE immediately; all registered outputs drop to 0.

## Timing
- Reset values:
  - state IDLE
  - `cnt` 0
  - `md_start` 0
  - `md_op` 0
  - `md_busy` 0
  - `hilo_we` 0
- Decode outputs have 0-cycle latency (combinational from inputs).
- Accept at edge k:
  - `md_start` high during cycle k+1
  - RUN during cycles k+1 … k+LAT
  - DONE / `hilo_we` during cycle k+LAT+1
  - IDLE from k+LAT+2
- `md_busy` is high for LAT+1 cycles.
- A dependent mfhi/mflo stalls through DONE. It issues in cycle k+LAT+2.

## Configuration
- `ALU_CTRL_DIV_EN` defined: div funct 011010 is accepted as above.
- `ALU_CTRL_DIV_EN` undefined:
  - div is treated as an unsupported funct: `illegal`=1, no accept.
  - `md_op` is tied to 0.
  - DIV_LAT is ignored.

## Structure
- Shared package `alu_ctrl_pkg` holds:
  - funct code constants (AND, OR, ADD, SUB, SLT, JR, MULT, DIV, MFHI, MFLO)
  - `alu_ctr` code constants
  - state enum (IDLE, RUN, DONE)
- One natural sub-module: `alu_funct_decode`, a purely combinational funct/ALUop → `alu_ctr`/class decode. The FSM and counter live in the top.

## Test plan
- `ALUop`=3'b010 with `valid` → `alu_ctr`=2, `stall`=0. R-type funct 000011 → `alu_ctr`=6. Funct 001000 → `jr`=1, `alu_ctr`=0.
- R-type funct 111111 with `valid`=1 → `illegal`=1. Same with `valid`=0 → `illegal`=0.
- mult accepted at edge 0, MULT_LAT=4:
  - `md_start` high in cycle 1 only
  - `md_busy` high in cycles 1–5
  - `hilo_we` high in cycle 5 only
  - `md_op`=0
- div accepted, then mflo held `valid` from cycle 1 → `stall`=1 through cycle DIV_LAT+1, 0 in cycle DIV_LAT+2. An add issued in cycle 2 → `stall`=0.
- `flush` in cycle 3 of a mult → IDLE in cycle 4, `hilo_we` never asserted. `flush` with a simultaneous mult request in IDLE → no `md_start`.
- `reset` asserted asynchronously mid-RUN → `md_busy`/`hilo_we`/`md_start` 0 immediately. Build without `ALU_CTRL_DIV_EN`: div → `illegal`=1, no `md_start`.
